// File: rtl/ir_key_sequencer_if.sv
// Command handshake between the IR key sequencer (master) and the calculator (slave).
interface ir_key_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [3:0] cmd_arg;

    modport master (output cmd_valid, cmd_type, cmd_arg, input cmd_ready);
    modport slave  (input cmd_valid, cmd_type, cmd_arg, output cmd_ready);
endinterface

// File: rtl/ir_key_sequencer.sv
// Turns IR key frames into queued calculator commands issued over a valid/ready handshake.
// Define IRSEQ_REPEAT_FILTER_EN to build the held-key repeat filter and holdoff counter.
module ir_key_sequencer #(
    parameter int HOLDOFF_CYC = 10000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        data_ready,
    input  logic [7:0]                  key_code,
    ir_key_sequencer_if.master          cmd,
    output logic                        ovf,
    output logic [7:0]                  last_key,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [1:0]  T_DIGIT  = 2'd0;
    localparam logic [1:0]  T_OP     = 2'd1;
    localparam logic [1:0]  T_EQUAL  = 2'd2;
    localparam logic [1:0]  T_CLEAR  = 2'd3;
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_ISSUE  = 1'b1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (HOLDOFF_CYC < 1 || HOLDOFF_CYC > 24'hFFFFFF) begin : g_bad_holdoff
        $error("HOLDOFF_CYC must lie in 1..2^24-1");
    end

    // Result is {known, type[1:0], arg[3:0]}; known=0 means the code is ignored.
    function automatic logic [6:0] classify(input logic [7:0] code);
        logic [6:0] r;
        r = 7'd0;
        if (code <= 8'h09) begin
            r = {1'b1, T_DIGIT, code[3:0]};
        end else begin
            case (code)
                8'h0F:   r = {1'b1, T_OP, 4'd0};
                8'h13:   r = {1'b1, T_OP, 4'd1};
                8'h10:   r = {1'b1, T_OP, 4'd2};
                8'h12:   r = {1'b1, T_OP, 4'd3};
                8'h17:   r = {1'b1, T_EQUAL, 4'd0};
                8'h0C:   r = {1'b1, T_CLEAR, 4'd0};
                default: r = 7'd0;
            endcase
        end
        return r;
    endfunction

    logic          dr_q;
    logic [6:0]    cls;
    logic          evt;
    logic          accept;
    logic          is_clear;
    logic          push;
    logic          drop;
    logic          pop;
    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [0:0]    state;

    assign cls      = classify(key_code);
    assign evt      = data_ready & ~dr_q;
    assign is_clear = (cls[5:4] == T_CLEAR);

`ifdef IRSEQ_REPEAT_FILTER_EN
    logic [23:0] holdoff;
    logic        rpt;

    // A repeat still reloads the holdoff, so a held key never gets through.
    assign rpt    = (key_code == last_key) && (holdoff != 24'd0);
    assign accept = evt && cls[6] && !rpt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdoff <= 24'd0;
        end else if (evt && cls[6]) begin
            holdoff <= 24'(HOLDOFF_CYC);
        end else if (holdoff != 24'd0) begin
            holdoff <= holdoff - 24'd1;
        end
    end
`else
    assign accept = evt && cls[6];
`endif

    // Full is judged on the pre-pop count, so a same-cycle pop does not make room.
    assign pop  = (state == S_IDLE) && (count != '0);
    assign push = accept && !is_clear && (count != FULL_CNT);
    assign drop = accept && !is_clear && (count == FULL_CNT);

    always_ff @(posedge clk) begin
        if (push || (accept && is_clear)) begin
            mem[wr_ptr] <= cls[5:0];
        end
    end

    // CLEAR flushes by moving the read pointer onto the slot it is written into.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_q     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            last_key <= 8'h00;
        end else begin
            dr_q <= data_ready;
            if (accept) begin
                last_key <= key_code;
            end
            if (accept && is_clear) begin
                rd_ptr <= wr_ptr;
                wr_ptr <= wr_ptr + 1'b1;
                count  <= (AW+1)'(1);
                ovf    <= 1'b0;
            end else begin
                if (drop) begin
                    ovf <= 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cmd.cmd_type <= 2'd0;
            cmd.cmd_arg  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {cmd.cmd_type, cmd.cmd_arg} <= mem[rd_ptr];
                        state <= S_ISSUE;
                    end
                end
                default: begin
                    if (cmd.cmd_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd.cmd_valid = (state == S_ISSUE);
    assign fifo_level    = count;

endmodule

// File: tb/tb_ir_key_sequencer.sv
// Directed bench for ir_key_sequencer; expectations follow IRSEQ_REPEAT_FILTER_EN if defined.
module tb_ir_key_sequencer;
    localparam int HOLD = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_ready;
    logic [7:0] key_code;
    logic       ovf;
    logic [7:0] last_key;
    logic [2:0] fifo_level;

    ir_key_sequencer_if cmd_if ();

    ir_key_sequencer #(.HOLDOFF_CYC(HOLD), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_ready (data_ready),
        .key_code   (key_code),
        .cmd        (cmd_if),
        .ovf        (ovf),
        .last_key   (last_key),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int         ncmd = 0;
    logic [1:0] log_type [64];
    logic [3:0] log_arg  [64];

    always @(posedge clk) begin
        if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            if (ncmd < 64) begin
                log_type[ncmd] <= cmd_if.cmd_type;
                log_arg[ncmd]  <= cmd_if.cmd_arg;
            end
            ncmd <= ncmd + 1;
        end
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        data_ready = 1'b1;
        key_code   = c;
        tick(1);
        data_ready = 1'b0;
    endtask

    initial begin
        int base;
        int exp_rep;
        rst = 1'b1;
        data_ready = 1'b0;
        key_code = 8'h00;
        cmd_if.cmd_ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(cmd_if.cmd_valid), 0);
        check("rst_type", 32'(cmd_if.cmd_type), 0);
        check("rst_arg", 32'(cmd_if.cmd_arg), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_last", 32'(last_key), 0);
        check("rst_level", 32'(fifo_level), 0);
        rst = 1'b0;
        tick(1);

        // Single digit: valid two cycles after the event, then handshake.
        send(8'h05);
        check("t1_level_n1", 32'(fifo_level), 1);
        check("t1_valid_n1", 32'(cmd_if.cmd_valid), 0);
        tick(1);
        check("t1_valid_n2", 32'(cmd_if.cmd_valid), 1);
        check("t1_type", 32'(cmd_if.cmd_type), 0);
        check("t1_arg", 32'(cmd_if.cmd_arg), 5);
        check("t1_last", 32'(last_key), 8'h05);
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        check("t1_valid_done", 32'(cmd_if.cmd_valid), 0);
        check("t1_level_done", 32'(fifo_level), 0);

        // Held operator key: five frames spaced inside the holdoff window.
`ifdef IRSEQ_REPEAT_FILTER_EN
        exp_rep = 1;
`else
        exp_rep = 5;
`endif
        base = ncmd;
        for (int i = 0; i < 5; i++) begin
            send(8'h0F);
            tick(19);
        end
        tick(4);
        check("t2_held_count", 32'(ncmd - base), 32'(exp_rep));
        check("t2_type", 32'(log_type[ncmd-1]), 1);
        check("t2_arg", 32'(log_arg[ncmd-1]), 0);
        tick(2 * HOLD);
        send(8'h0F);
        tick(4);
        check("t2_after_gap", 32'(ncmd - base), 32'(exp_rep + 1));

        // Same digit in three frames.
`ifdef IRSEQ_REPEAT_FILTER_EN
        exp_rep = 1;
`else
        exp_rep = 3;
`endif
        base = ncmd;
        for (int i = 0; i < 3; i++) begin
            send(8'h07);
            tick(19);
        end
        tick(4);
        check("t6_count", 32'(ncmd - base), 32'(exp_rep));
        check("t6_type", 32'(log_type[ncmd-1]), 0);
        check("t6_arg", 32'(log_arg[ncmd-1]), 7);

        // Backpressure: first key is presented, four queue, the sixth overflows.
        cmd_if.cmd_ready = 1'b0;
        send(8'h01); tick(1);
        send(8'h02); tick(1);
        send(8'h03); tick(1);
        send(8'h04); tick(1);
        send(8'h13); tick(1);
        send(8'h17); tick(1);
        check("t3_level_full", 32'(fifo_level), 4);
        check("t3_ovf", 32'(ovf), 1);
        check("t3_last", 32'(last_key), 8'h17);
        check("t3_valid", 32'(cmd_if.cmd_valid), 1);
        tick(5);
        check("t3_hold_valid", 32'(cmd_if.cmd_valid), 1);
        check("t3_hold_arg", 32'(cmd_if.cmd_arg), 1);
        base = ncmd;
        cmd_if.cmd_ready = 1'b1;
        tick(12);
        check("t3_drained", 32'(ncmd - base), 5);
        for (int i = 0; i < 4; i++) begin
            check("t3_order_type", 32'(log_type[base+i]), 0);
            check("t3_order_arg", 32'(log_arg[base+i]), 32'(i + 1));
        end
        check("t3_sub_type", 32'(log_type[base+4]), 1);
        check("t3_sub_arg", 32'(log_arg[base+4]), 1);
        check("t3_ovf_sticky", 32'(ovf), 1);
        check("t3_level_empty", 32'(fifo_level), 0);

        // CLEAR while a digit is presented and three are queued.
        cmd_if.cmd_ready = 1'b0;
        send(8'h06); tick(1);
        send(8'h07); tick(1);
        send(8'h08); tick(1);
        send(8'h09); tick(1);
        check("t4_level_pre", 32'(fifo_level), 3);
        check("t4_ovf_pre", 32'(ovf), 1);
        send(8'h0C);
        check("t4_level_clr", 32'(fifo_level), 1);
        check("t4_ovf_clr", 32'(ovf), 0);
        check("t4_valid_keep", 32'(cmd_if.cmd_valid), 1);
        check("t4_arg_keep", 32'(cmd_if.cmd_arg), 6);
        base = ncmd;
        cmd_if.cmd_ready = 1'b1;
        tick(6);
        check("t4_count", 32'(ncmd - base), 2);
        check("t4_first_arg", 32'(log_arg[base]), 6);
        check("t4_clear_type", 32'(log_type[base+1]), 3);
        check("t4_clear_arg", 32'(log_arg[base+1]), 0);
        check("t4_level_end", 32'(fifo_level), 0);

        // Unclassified codes are ignored entirely.
        cmd_if.cmd_ready = 1'b0;
        base = ncmd;
        send(8'h1A); tick(1);
        send(8'h16); tick(3);
        check("t5_ign_valid", 32'(cmd_if.cmd_valid), 0);
        check("t5_ign_last", 32'(last_key), 8'h0C);
        check("t5_ign_level", 32'(fifo_level), 0);

        // Asynchronous reset while a command is presented.
        send(8'h05); tick(1);
        send(8'h03);
        check("t5_pre_valid", 32'(cmd_if.cmd_valid), 1);
        check("t5_pre_level", 32'(fifo_level), 1);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(cmd_if.cmd_valid), 0);
        check("t5_rst_type", 32'(cmd_if.cmd_type), 0);
        check("t5_rst_arg", 32'(cmd_if.cmd_arg), 0);
        check("t5_rst_ovf", 32'(ovf), 0);
        check("t5_rst_last", 32'(last_key), 0);
        check("t5_rst_level", 32'(fifo_level), 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        send(8'h09);
        tick(1);
        check("t5_post_valid", 32'(cmd_if.cmd_valid), 1);
        check("t5_post_arg", 32'(cmd_if.cmd_arg), 9);
        check("t5_post_last", 32'(last_key), 8'h09);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
